// File: rtl/keypad_ctrl_if.sv
// Keypad controller bus: encoder-side inputs, event-stream outputs and status.
// Event stream handshake: ev_code is valid while ev_valid=1 and is held stable until
// the cycle in which ev_ready=1 is also high; that cycle transfers one event.
interface keypad_ctrl_if #(
    parameter int CODE_W     = 5,
    parameter int FIFO_DEPTH = 4
);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    logic [CODE_W-1:0] key_code;
    logic              key_strobe;
    logic              flush;
    logic [CODE_W-1:0] ev_code;
    logic              ev_valid;
    logic              ev_ready;
    logic [OCC_W-1:0]  fifo_count;
    logic              overflow;
    logic              busy;
    logic [1:0]        dbg_state;

    modport master (
        output key_code, key_strobe, flush, ev_ready,
        input  ev_code, ev_valid, fifo_count, overflow, busy, dbg_state
    );

    modport slave (
        input  key_code, key_strobe, flush, ev_ready,
        output ev_code, ev_valid, fifo_count, overflow, busy, dbg_state
    );
endinterface

// File: rtl/keypad_ctrl.sv
// Debounces keypad encoder presses (one event per press, full release required)
// and queues accepted key codes in a small FIFO drained by a valid/ready consumer.
module keypad_ctrl #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int CODE_W       = 5
) (
    input  logic          clk,
    input  logic          rst,
    keypad_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic              push;

    logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]  count_q;
    logic              overflow_q;
    logic              full, pop, do_push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.key_strobe) begin
                    cand_d  = bus.key_code;
                    cnt_d   = CNT_W'(1);
                    state_d = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                // A code change aborts the candidate; the new code restarts from IDLE.
                if (!bus.key_strobe || (bus.key_code != cand_q)) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    push    = 1'b1;
                    state_d = S_HELD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HELD: begin
                if (!bus.key_strobe) begin
                    cnt_d   = CNT_W'(1);
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (bus.key_strobe) begin
                    state_d = S_HELD;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign full    = (count_q == OCC_W'(FIFO_DEPTH));
    assign pop     = bus.ev_valid && bus.ev_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push && full && !pop;
            if (do_push) begin
                mem_q[wr_ptr_q] <= cand_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    assign bus.ev_valid   = (count_q != '0);
    assign bus.ev_code    = mem_q[rd_ptr_q];
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_keypad_ctrl.sv
// Bench for keypad_ctrl: scenario tasks plus a scoreboard that checks every popped event.
module tb_keypad_ctrl;
    localparam int DEBOUNCE_CYC = 4;
    localparam int FIFO_DEPTH   = 4;
    localparam int CODE_W       = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ovf_cnt;
    int   pop_cnt;
    logic [CODE_W-1:0] exp_q[$];

    keypad_ctrl_if #(.CODE_W(CODE_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    keypad_ctrl #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .CODE_W      (CODE_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor();
        logic [CODE_W-1:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.overflow) ovf_cnt++;
                if (bus.ev_valid && bus.ev_ready) begin
                    pop_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL pop_unexpected: got code %0d, expected no event", bus.ev_code);
                    end else begin
                        exp = exp_q.pop_front();
                        if (bus.ev_code !== exp) begin
                            errors++;
                            $display("FAIL pop_code: got %0d, expected %0d", bus.ev_code, exp);
                        end
                    end
                end
            end
        end
    endtask

    task automatic press(input logic [CODE_W-1:0] code, input int hi, input int lo);
        bus.key_code   = code;
        bus.key_strobe = 1'b1;
        step(hi);
        bus.key_strobe = 1'b0;
        step(lo);
    endtask

    task automatic drain();
        int n;
        bus.ev_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step(1);
            n++;
        end
        bus.ev_ready = 1'b0;
        step(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d events still expected, expected 0", exp_q.size());
        end
        checks++;
        if (bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL drain_count: got %0d, expected 0", bus.fifo_count);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.ev_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.busy !== 1'b0 ||
            bus.overflow !== 1'b0 || bus.ev_code !== 5'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b count=%0d busy=%b ovf=%b code=%0d, expected all 0",
                     bus.ev_valid, bus.fifo_count, bus.busy, bus.overflow, bus.ev_code);
        end
        rst = 1'b1;
        step(1);
    endtask

    task automatic test_latency();
        int first_k, hi_cnt;
        first_k = -1;
        hi_cnt  = 0;
        pop_cnt = 0;
        bus.ev_ready   = 1'b1;
        bus.key_code   = 5'd7;
        bus.key_strobe = 1'b1;
        exp_q.push_back(5'd7);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.ev_valid) begin
                hi_cnt++;
                if (first_k < 0) first_k = k;
            end
            @(posedge clk);
            #1;
            if (k == 9) bus.key_strobe = 1'b0;
        end
        bus.ev_ready = 1'b0;
        checks++;
        if (first_k != DEBOUNCE_CYC) begin
            errors++;
            $display("FAIL latency_first_valid: got cycle %0d, expected %0d", first_k, DEBOUNCE_CYC);
        end
        checks++;
        if (hi_cnt != 1 || pop_cnt != 1) begin
            errors++;
            $display("FAIL latency_valid_width: got %0d valid cycles %0d pops, expected 1 and 1", hi_cnt, pop_cnt);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL latency_idle: got busy=%b, expected 0", bus.busy);
        end
    endtask

    task automatic test_bounce();
        pop_cnt = 0;
        bus.ev_ready = 1'b1;
        press(5'd5, DEBOUNCE_CYC - 1, 3);
        bus.ev_ready = 1'b0;
        checks++;
        if (pop_cnt != 0 || bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL bounce_event: got %0d pops count %0d, expected 0 and 0", pop_cnt, bus.fifo_count);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL bounce_busy: got %b, expected 0", bus.busy);
        end
    endtask

    task automatic test_code_change();
        pop_cnt = 0;
        bus.ev_ready   = 1'b1;
        exp_q.push_back(5'd9);
        bus.key_code   = 5'd3;
        bus.key_strobe = 1'b1;
        step(2);
        bus.key_code   = 5'd9;
        step(6);
        bus.key_code   = 5'd12;
        step(3);
        bus.key_strobe = 1'b0;
        step(DEBOUNCE_CYC + 2);
        bus.ev_ready = 1'b0;
        checks++;
        if (pop_cnt != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL code_change_events: got %0d pops %0d pending, expected 1 and 0", pop_cnt, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        ovf_cnt = 0;
        bus.ev_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c <= FIFO_DEPTH) exp_q.push_back(CODE_W'(c));
            press(CODE_W'(c), 6, DEBOUNCE_CYC);
        end
        checks++;
        if (bus.fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL overflow_count: got %0d, expected 4", bus.fifo_count);
        end
        checks++;
        if (ovf_cnt != 1) begin
            errors++;
            $display("FAIL overflow_pulses: got %0d, expected 1", ovf_cnt);
        end
        drain();
    endtask

    task automatic test_full_push_pop();
        ovf_cnt = 0;
        bus.ev_ready = 1'b0;
        for (int c = 1; c <= FIFO_DEPTH; c++) begin
            exp_q.push_back(CODE_W'(c));
            press(CODE_W'(c), 6, DEBOUNCE_CYC);
        end
        exp_q.push_back(5'd10);
        bus.key_code   = 5'd10;
        bus.key_strobe = 1'b1;
        step(DEBOUNCE_CYC - 1);
        bus.ev_ready = 1'b1;
        step(1);
        bus.ev_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.fifo_count !== 3'd4 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: got count %0d ovf %b, expected 4 and 0", bus.fifo_count, bus.overflow);
        end
        @(posedge clk);
        #1;
        bus.key_strobe = 1'b0;
        step(DEBOUNCE_CYC);
        checks++;
        if (ovf_cnt != 0) begin
            errors++;
            $display("FAIL full_push_pop_ovf: got %0d pulses, expected 0", ovf_cnt);
        end
        drain();
    endtask

    task automatic test_flush();
        bus.ev_ready = 1'b0;
        exp_q.push_back(5'd6);
        press(5'd6, 6, DEBOUNCE_CYC);
        exp_q.push_back(5'd17);
        press(5'd17, 6, DEBOUNCE_CYC);
        checks++;
        if (bus.fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL flush_prefill: got %0d, expected 2", bus.fifo_count);
        end
        bus.flush = 1'b1;
        step(1);
        bus.flush = 1'b0;
        exp_q.delete();
        checks++;
        if (bus.fifo_count !== 3'd0 || bus.ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: got count %0d valid %b, expected 0 and 0", bus.fifo_count, bus.ev_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [CODE_W-1:0] c;
        pop_cnt = 0;
        bus.ev_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            c = CODE_W'($urandom_range(0, 19));
            exp_q.push_back(c);
            press(c, $urandom_range(DEBOUNCE_CYC, DEBOUNCE_CYC + 4), DEBOUNCE_CYC);
        end
        step(2);
        bus.ev_ready = 1'b0;
        checks++;
        if (pop_cnt != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL back_to_back: got %0d pops %0d pending, expected 6 and 0", pop_cnt, exp_q.size());
        end
    endtask

    task automatic test_async_reset_mid();
        pop_cnt = 0;
        bus.ev_ready = 1'b0;
        exp_q.push_back(5'd1);
        press(5'd1, 6, DEBOUNCE_CYC);
        exp_q.push_back(5'd2);
        press(5'd2, 6, DEBOUNCE_CYC);
        bus.key_code   = 5'd3;
        bus.key_strobe = 1'b1;
        step(2);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.ev_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b count=%0d busy=%b, expected 0 0 0",
                     bus.ev_valid, bus.fifo_count, bus.busy);
        end
        exp_q.delete();
        bus.key_strobe = 1'b0;
        #2 rst = 1'b1;
        step(1);
        bus.ev_ready = 1'b1;
        step(6);
        bus.ev_ready = 1'b0;
        checks++;
        if (pop_cnt != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_after: got %0d pops busy=%b, expected 0 and 0", pop_cnt, bus.busy);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        ovf_cnt        = 0;
        pop_cnt        = 0;
        rst            = 1'b0;
        bus.key_code   = '0;
        bus.key_strobe = 1'b0;
        bus.flush      = 1'b0;
        bus.ev_ready   = 1'b0;
        fork
            monitor();
        join_none
        #3;
        test_reset();
        test_latency();
        test_bounce();
        test_code_change();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_back_to_back();
        test_async_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
